// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Optional feature macro: PROG_LOADER_CKSUM_EN adds the trailing checksum byte and CK state.
package prog_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_WRITE,
`ifdef PROG_LOADER_CKSUM_EN
    S_CK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_CKS  = 2'b11;

  // States in which a frame byte may be taken from the receive front end.
  function automatic logic takes_byte(input state_t s);
    logic r;
    r = (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DAT_HI) || (s == S_DAT_LO);
`ifdef PROG_LOADER_CKSUM_EN
    r = r || (s == S_CK);
`endif
    return r;
  endfunction

  // States in which the loader is quiescent and the processor may run.
  function automatic logic is_quiet(input state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// Inter-byte idle timer for the program loader: counts cycles while enabled,
// flags expiry on the TIMEOUT_CYC-th consecutive idle cycle.
module loader_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Idle-cycle counter; saturates at LAST so expiry stays asserted until cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a framed big-endian byte stream (LEN_HI, LEN_LO, N x (HI, LO)
// [, CKSUM]) and writes 16-bit words into the instruction RAM, holding the CPU meanwhile.
// Optional feature macro: PROG_LOADER_CKSUM_EN (trailing 8-bit additive checksum).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [16:0] DEPTH_17 = 17'(DEPTH);

  state_t      state;
  logic [7:0]  hi_byte;
  logic [15:0] len;
  logic [15:0] widx;
  logic        xfer;
  logic        start_go;
  logic        expire;
  logic [15:0] len_rx;

  assign rx_ready = takes_byte(state);
  assign cpu_hold = !is_quiet(state);
  assign xfer     = rx_valid && rx_ready;
  assign start_go = start && is_quiet(state);
  assign len_rx   = {hi_byte, rx_data};

  // RAM address of word k; wraps modulo DEPTH through truncation.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [15:0] k);
    return ADDR_W'(BASE_ADDR + int'(k));
  endfunction

  loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (xfer || start_go),
    .en    (rx_ready),
    .expire(expire)
  );

`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0] cksum;

  // Running mod-256 sum of every byte from LEN_HI through the last data LO byte.
  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      cksum <= '0;
    end else if (xfer && (state != S_CK)) begin
      cksum <= cksum + rx_data;
    end
  end
`endif

  // Frame FSM with registered RAM write port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mem_wren <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      len      <= '0;
      widx     <= '0;
    end else begin
      mem_wren <= 1'b0;
      // A byte arriving in the expiry cycle takes priority over the abort.
      if (expire && !xfer) begin
        state    <= S_ERR;
        err      <= 1'b1;
        err_code <= ERR_TMO;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
              state    <= S_LEN_HI;
              done     <= 1'b0;
              err      <= 1'b0;
              err_code <= ERR_NONE;
              widx     <= '0;
            end
          end
          S_LEN_HI: begin
            if (xfer) begin
              hi_byte <= rx_data;
              state   <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (xfer) begin
              len <= len_rx;
              if (len_rx == 16'd0) begin
`ifdef PROG_LOADER_CKSUM_EN
                state <= S_CK;
`else
                state <= S_DONE;
                done  <= 1'b1;
`endif
              end else if ({1'b0, len_rx} > DEPTH_17) begin
                state    <= S_ERR;
                err      <= 1'b1;
                err_code <= ERR_LEN;
              end else begin
                state <= S_DAT_HI;
              end
            end
          end
          S_DAT_HI: begin
            if (xfer) begin
              hi_byte <= rx_data;
              state   <= S_DAT_LO;
            end
          end
          S_DAT_LO: begin
            if (xfer) begin
              mem_wren <= 1'b1;
              mem_data <= {hi_byte, rx_data};
              mem_addr <= word_addr(widx);
              state    <= S_WRITE;
            end
          end
          S_WRITE: begin
            widx <= widx + 16'd1;
            if ((widx + 16'd1) == len) begin
`ifdef PROG_LOADER_CKSUM_EN
              state <= S_CK;
`else
              state <= S_DONE;
              done  <= 1'b1;
`endif
            end else begin
              state <= S_DAT_HI;
            end
          end
`ifdef PROG_LOADER_CKSUM_EN
          S_CK: begin
            if (xfer) begin
              if (rx_data == cksum) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state    <= S_ERR;
                err      <= 1'b1;
                err_code <= ERR_CKS;
              end
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader (ADDR_W=8, BASE_ADDR=0, TIMEOUT_CYC=16).
module tb_prog_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (0),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_ready(rx_ready),
    .mem_wren(mem_wren),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .cpu_hold(cpu_hold),
    .done    (done),
    .err     (err),
    .err_code(err_code)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_wren = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every RAM write must match the head of the expectation queue.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (mem_wren) begin
      check("wren_one_cycle", {31'd0, prev_wren}, 32'd0);
      check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        check("wr_data", {16'd0, mem_data}, {16'd0, e.data});
      end
    end
    prev_wren = mem_wren;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: byte %0h not accepted within 64 cycles", b);
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic status(input string name, input logic d, input logic e, input logic [1:0] c,
                        input logic h);
    check({name, "_done"}, {31'd0, done}, {31'd0, d});
    check({name, "_err"}, {31'd0, err}, {31'd0, e});
    check({name, "_code"}, {30'd0, err_code}, {30'd0, c});
    check({name, "_hold"}, {31'd0, cpu_hold}, {31'd0, h});
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] iv;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    status("reset", 1'b0, 1'b0, 2'b00, 1'b0);
    check("reset_wren", {31'd0, mem_wren}, 32'd0);
    check("reset_addr", {24'd0, mem_addr}, 32'd0);
    check("reset_data", {16'd0, mem_data}, 32'd0);
    check("reset_ready", {31'd0, rx_ready}, 32'd0);

    // Reset mid-frame: loader sits in DAT_LO, rst for 3 cycles, no write may follow
    do_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    rx_valid = 1'b0;
    check("midframe_hold", {31'd0, cpu_hold}, 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);
    status("midrst", 1'b0, 1'b0, 2'b00, 1'b0);
    check("midrst_ready", {31'd0, rx_ready}, 32'd0);
    check("midrst_wren", {31'd0, mem_wren}, 32'd0);

    // Two-word frame; checksum 00+02+12+34+AB+CD = 0x1C0 -> 0xC0
    do_start();
    check("t2_hold_start", {31'd0, cpu_hold}, 32'd1);
    push(8'd0, 16'h1234);
    push(8'd1, 16'hABCD);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(16'h1234);
    send_word(16'hABCD);
`ifdef PROG_LOADER_CKSUM_EN
    send_byte(8'hC0);
`endif
    idle(3);
    status("t2", 1'b1, 1'b0, 2'b00, 1'b0);
    check("t2_q_empty", exp_q.size(), 32'd0);

    // N = 0: done without writes
    do_start();
    check("t3_done_cleared", {31'd0, done}, 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef PROG_LOADER_CKSUM_EN
    send_byte(8'h00);
`endif
    idle(3);
    status("t3_n0", 1'b1, 1'b0, 2'b00, 1'b0);

    // N = 0x0101 = 257 > DEPTH 256 -> length error
    do_start();
    send_byte(8'h01);
    send_byte(8'h01);
    idle(3);
    status("t3_len", 1'b0, 1'b1, 2'b01, 1'b0);
    check("t3_err_ready", {31'd0, rx_ready}, 32'd0);

    // Byte landing exactly in the 16th idle cycle beats the timeout
    // checksum 00+01+77+88 = 0x100 -> 0x00
    do_start();
    check("t4_err_cleared", {31'd0, err}, 32'd0);
    push(8'd0, 16'h7788);
    send_byte(8'h00);
    idle(15);
    send_byte(8'h01);
    send_word(16'h7788);
`ifdef PROG_LOADER_CKSUM_EN
    send_byte(8'h00);
`endif
    idle(3);
    status("t4_edge", 1'b1, 1'b0, 2'b00, 1'b0);
    check("t4_edge_q", exp_q.size(), 32'd0);

    // 20-cycle stall between HI and LO -> timeout, no write for that word
    do_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h55);
    idle(20);
    status("t4_tmo", 1'b0, 1'b1, 2'b10, 1'b0);
    check("t4_tmo_q", exp_q.size(), 32'd0);

`ifdef PROG_LOADER_CKSUM_EN
    // Wrong checksum (correct is 0xC0): words kept, checksum error
    do_start();
    push(8'd0, 16'h1234);
    push(8'd1, 16'hABCD);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(16'h1234);
    send_word(16'hABCD);
    send_byte(8'hC1);
    idle(3);
    status("t5_cks", 1'b0, 1'b1, 2'b11, 1'b0);
    check("t5_q_empty", exp_q.size(), 32'd0);
`endif

    // Full RAM, rx_valid held high, start pulsed mid-load
    // word i = {~i, i}; each word sums to 0xFF, 256 words -> 0; plus 01+00 -> checksum 0x01
    do_start();
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      push(iv, {~iv, iv});
      if (i == 100) start = 1'b1;
      if (i == 128) begin
        check("t6_hold_mid", {31'd0, cpu_hold}, 32'd1);
        check("t6_done_mid", {31'd0, done}, 32'd0);
      end
      send_word({~iv, iv});
      start = 1'b0;
    end
`ifdef PROG_LOADER_CKSUM_EN
    send_byte(8'h01);
`endif
    idle(3);
    status("t6_full", 1'b1, 1'b0, 2'b00, 1'b0);
    check("t6_q_empty", exp_q.size(), 32'd0);
    check("t6_last_addr", {24'd0, mem_addr}, 32'h0000_00FF);

    // Reload after DONE; checksum 00+01+BE+EF = 0x1AE -> 0xAE
    do_start();
    push(8'd0, 16'hBEEF);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(16'hBEEF);
`ifdef PROG_LOADER_CKSUM_EN
    send_byte(8'hAE);
`endif
    idle(3);
    status("t6_reload", 1'b1, 1'b0, 2'b00, 1'b0);
    check("t6_reload_q", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
